// File: rtl/instr_ctrl.sv
// Instruction control: owns PC/IR, decodes 4-bit opcodes against the FETCH/EXEC1/EXEC2
// phase strobes, drives datapath strobes, and tracks halt, illegal opcodes and retirements.
module instr_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FETCH,
  input  logic             EXEC1,
  input  logic             EXEC2,
  input  logic [15:0]      IMEM_DATA,
  input  logic             Z,
  output logic [PC_W-1:0]  IMEM_ADDR,
  output logic [15:0]      IR,
  output logic             E2,
  output logic             REG_WE,
  output logic             MEM_RD,
  output logic             MEM_WE,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;
  logic            ph_fetch, ph_exec1, ph_exec2;
  logic            run;
  logic            is_alu, is_ld, is_st, is_jmp, is_jz, is_halt, is_illegal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A phase is only valid when exactly one strobe is high.
  assign ph_fetch = FETCH & ~EXEC1 & ~EXEC2;
  assign ph_exec1 = ~FETCH & EXEC1 & ~EXEC2;
  assign ph_exec2 = ~FETCH & ~EXEC1 & EXEC2;
  assign run      = ~HALTED;

  assign opcode     = IR[15:12];
  assign is_alu     = (opcode == OP_ALU);
  assign is_ld      = (opcode == OP_LD);
  assign is_st      = (opcode == OP_ST);
  assign is_jmp     = (opcode == OP_JMP);
  assign is_jz      = (opcode == OP_JZ);
  assign is_halt    = (opcode == OP_HALT);
  assign is_illegal = ~(opcode == OP_NOP || is_alu || is_ld || is_st ||
                        is_jmp || is_jz || is_halt);

  assign IMEM_ADDR = pc;
  assign E2        = run & ph_exec1 & is_ld;
  assign MEM_RD    = run & ph_exec1 & is_ld;
  assign MEM_WE    = run & ph_exec1 & is_st;
  assign REG_WE    = run & ((ph_exec1 & is_alu) | (ph_exec2 & is_ld));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc      <= '0;
      IR      <= '0;
      HALTED  <= 1'b0;
      ILLEGAL <= 1'b0;
      RETIRED <= '0;
    end else if (run) begin
      if (ph_fetch) begin
        IR <= IMEM_DATA;
        pc <= pc + PC_ONE;
      end
      // Jumps overwrite the PC+1 written at the preceding FETCH edge: no delay slot.
      if (ph_exec1) begin
        if (is_jmp || (is_jz && Z))
          pc <= IR[PC_W-1:0];
        if (is_halt)
          HALTED <= 1'b1;
        if (is_illegal)
          ILLEGAL <= 1'b1;
        if (!is_ld)
          RETIRED <= sat_inc(RETIRED);
      end
      if (ph_exec2 && is_ld)
        RETIRED <= sat_inc(RETIRED);
    end
  end

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed table-driven bench for instr_ctrl with a few hand-written multi-cycle sequences.
module tb_instr_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        FETCH = 1'b0, EXEC1 = 1'b0, EXEC2 = 1'b0, Z = 1'b0;
  logic [15:0] IMEM_DATA;
  logic [7:0]  IMEM_ADDR;
  logic [15:0] IR;
  logic        E2, REG_WE, MEM_RD, MEM_WE, HALTED, ILLEGAL;
  logic [15:0] RETIRED;

  logic [15:0] mem [256];
  assign IMEM_DATA = mem[IMEM_ADDR];

  always #5 CLK = ~CLK;

  instr_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
    .IMEM_DATA(IMEM_DATA), .Z(Z), .IMEM_ADDR(IMEM_ADDR), .IR(IR), .E2(E2),
    .REG_WE(REG_WE), .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .HALTED(HALTED),
    .ILLEGAL(ILLEGAL), .RETIRED(RETIRED)
  );

  // in = {FETCH, EXEC1, EXEC2, Z}; flags = {E2, REG_WE, MEM_RD, MEM_WE, HALTED, ILLEGAL}
  typedef struct {
    logic [3:0]  in;
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [5:0]  flags;
    logic [15:0] ret;
  } vec_t;

  vec_t tbl [27];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] snap();
    return {18'd0, IMEM_ADDR, IR, E2, REG_WE, MEM_RD, MEM_WE, HALTED, ILLEGAL, RETIRED};
  endfunction

  // Called at posedge+1; drives a phase and advances to the next posedge+1.
  task automatic phase(input logic [3:0] in);
    {FETCH, EXEC1, EXEC2, Z} = in;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    {FETCH, EXEC1, EXEC2, Z} = 4'b0000;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1000; mem[8'h01] = 16'h2000; mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'h4010; mem[8'h10] = 16'h3000; mem[8'h11] = 16'h5020;
    mem[8'h12] = 16'h5030; mem[8'h30] = 16'h7000; mem[8'h31] = 16'hF000;
    mem[8'h32] = 16'h2000;

    tbl[0]  = '{4'b0000, 8'h00, 16'h0000, 6'b000000, 16'd0};
    tbl[1]  = '{4'b1000, 8'h00, 16'h0000, 6'b000000, 16'd0};
    tbl[2]  = '{4'b0100, 8'h01, 16'h1000, 6'b010000, 16'd0};
    tbl[3]  = '{4'b1000, 8'h01, 16'h1000, 6'b000000, 16'd1};
    tbl[4]  = '{4'b0100, 8'h02, 16'h2000, 6'b101000, 16'd1};
    tbl[5]  = '{4'b0010, 8'h02, 16'h2000, 6'b010000, 16'd1};
    tbl[6]  = '{4'b1000, 8'h02, 16'h2000, 6'b000000, 16'd2};
    tbl[7]  = '{4'b0100, 8'h03, 16'h0000, 6'b000000, 16'd2};
    tbl[8]  = '{4'b1100, 8'h03, 16'h0000, 6'b000000, 16'd3};
    tbl[9]  = '{4'b1000, 8'h03, 16'h0000, 6'b000000, 16'd3};
    tbl[10] = '{4'b0100, 8'h04, 16'h4010, 6'b000000, 16'd3};
    tbl[11] = '{4'b1000, 8'h10, 16'h4010, 6'b000000, 16'd4};
    tbl[12] = '{4'b0100, 8'h11, 16'h3000, 6'b000100, 16'd4};
    tbl[13] = '{4'b0010, 8'h11, 16'h3000, 6'b000000, 16'd5};
    tbl[14] = '{4'b1000, 8'h11, 16'h3000, 6'b000000, 16'd5};
    tbl[15] = '{4'b0100, 8'h12, 16'h5020, 6'b000000, 16'd5};
    tbl[16] = '{4'b1000, 8'h12, 16'h5020, 6'b000000, 16'd6};
    tbl[17] = '{4'b0101, 8'h13, 16'h5030, 6'b000000, 16'd6};
    tbl[18] = '{4'b1000, 8'h30, 16'h5030, 6'b000000, 16'd7};
    tbl[19] = '{4'b0100, 8'h31, 16'h7000, 6'b000000, 16'd7};
    tbl[20] = '{4'b1000, 8'h31, 16'h7000, 6'b000001, 16'd8};
    tbl[21] = '{4'b0100, 8'h32, 16'hF000, 6'b000001, 16'd8};
    tbl[22] = '{4'b1000, 8'h32, 16'hF000, 6'b000011, 16'd9};
    tbl[23] = '{4'b0100, 8'h32, 16'hF000, 6'b000011, 16'd9};
    tbl[24] = '{4'b1000, 8'h32, 16'hF000, 6'b000011, 16'd9};
    tbl[25] = '{4'b0100, 8'h32, 16'hF000, 6'b000011, 16'd9};
    tbl[26] = '{4'b0010, 8'h32, 16'hF000, 6'b000011, 16'd9};

    do_reset();

    for (int i = 0; i < 27; i++) begin
      {FETCH, EXEC1, EXEC2, Z} = tbl[i].in;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), snap(),
          {18'd0, tbl[i].addr, tbl[i].ir, tbl[i].flags, tbl[i].ret});
      @(posedge CLK); #1;
    end

    // Reset clears the sticky flags and the counter.
    do_reset();
    chk("reset_state", snap(), 64'd0);

    // PC wraps from 0xFF to 0x00.
    mem[8'h00] = 16'h40FF;
    mem[8'hFF] = 16'h0000;
    phase(4'b1000);
    phase(4'b0100);
    chk("jmp_ff_addr", {56'd0, IMEM_ADDR}, 64'hFF);
    phase(4'b1000);
    chk("wrap_addr", {56'd0, IMEM_ADDR}, 64'h00);
    chk("wrap_ir", {48'd0, IR}, 64'h0000);

    // Asynchronous reset in the middle of an LD's EXEC2.
    do_reset();
    mem[8'h00] = 16'h2000;
    phase(4'b1000);
    phase(4'b0100);
    {FETCH, EXEC1, EXEC2, Z} = 4'b0010;
    @(negedge CLK);
    chk("ld_e2_regwe", {63'd0, REG_WE}, 64'd1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_regwe", {63'd0, REG_WE}, 64'd0);
    chk("async_rst_state", snap(), 64'd0);
    @(posedge CLK); #1;
    {FETCH, EXEC1, EXEC2, Z} = 4'b0000;
    #2 RST_N = 1'b1;
    @(posedge CLK); #1;
    mem[8'h00] = 16'h1000;
    {FETCH, EXEC1, EXEC2, Z} = 4'b1000;
    @(negedge CLK);
    chk("post_rst_fetch_addr", {56'd0, IMEM_ADDR}, 64'h00);
    @(posedge CLK); #1;
    chk("post_rst_ir", {48'd0, IR}, 64'h1000);

    // Two strobes high at once is idle: no strobes, no state change.
    {FETCH, EXEC1, EXEC2, Z} = 4'b0110;
    @(negedge CLK);
    chk("dual_strobe_regwe", {63'd0, REG_WE}, 64'd0);
    @(posedge CLK); #1;
    chk("dual_strobe_state", snap(), {18'd0, 8'h01, 16'h1000, 6'b000000, 16'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_ctrl.md
# instr_ctrl

Instruction-control block that sits opposite the CPU phase sequencer: it consumes the one-hot FETCH/EXEC1/EXEC2 phase strobes and returns E2, the "needs second execute cycle" request. It owns the program counter and instruction register, decodes the 4-bit opcode, and drives the per-phase datapath strobes for the register file and data memory. It also provides halt handling, illegal-opcode flagging and a retired-instruction counter.

## Interface
- PC_W, 8: program-counter / instruction-address width.
- CNT_W, 16: retired-instruction counter width.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FETCH  in  1  phase strobe from sequencer.
- EXEC1  in  1  phase strobe from sequencer.
- EXEC2  in  1  phase strobe from sequencer.
- IMEM_DATA  in  16  instruction word; asynchronous-read memory, valid while IMEM_ADDR is stable.
- Z  in  1  ALU zero flag, sampled in EXEC1.
- IMEM_ADDR  out  PC_W  equals PC (combinational).
- IR  out  16  instruction register.
- E2  out  1  request EXEC2, combinational.
- REG_WE  out  1  register-file write strobe, combinational.
- MEM_RD  out  1  data-memory read strobe, combinational.
- MEM_WE  out  1  data-memory write strobe, combinational.
- HALTED  out  1  sticky halt flag.
- ILLEGAL  out  1  sticky illegal-opcode flag.
- RETIRED  out  CNT_W  retired-instruction count.

## Operation
- Phase valid only when exactly one of FETCH/EXEC1/EXEC2 is high. Zero or more than one high means idle: no register updates and all strobes 0.
- Opcode is IR[15:12]. Target is IR[PC_W-1:0].
  - 0x0 NOP: no side effects.
  - 0x1 ALU: REG_WE=1 during EXEC1.
  - 0x2 LD: MEM_RD=1 and E2=1 during EXEC1; REG_WE=1 during EXEC2.
  - 0x3 ST: MEM_WE=1 during EXEC1.
  - 0x4 JMP: PC <= target at the EXEC1 edge.
  - 0x5 JZ: PC <= target at the EXEC1 edge if Z=1; otherwise no change.
  - 0xF HALT: HALTED <= 1 at the EXEC1 edge.
  - Any other opcode: behaves as NOP; ILLEGAL <= 1 at the EXEC1 edge.
- FETCH edge, not halted: IR <= IMEM_DATA; PC <= PC+1, modulo 2^PC_W (0xFF wraps to 0x00).
- Halted:
  - FETCH does not load IR or advance PC.
  - E2, REG_WE, MEM_RD and MEM_WE are forced to 0.
  - RETIRED is frozen.
  - Only RST_N clears HALTED.
- E2 is asserted only in EXEC1 with opcode LD; 0 in all other phases and opcodes.
- EXEC2 with a non-LD IR (sequencer fault): no strobes and no retirement.
- RETIRED increments once per instruction, on its final execute edge: the EXEC2 edge for LD, the EXEC1 edge for all others, including HALT and illegal opcodes.
- RETIRED saturates at 2^CNT_W-1.

## Timing
- Reset (RST_N low, asynchronous): PC=0, IR=0x0000, HALTED=0, ILLEGAL=0, RETIRED=0. All combinational outputs evaluate to 0 because IR decodes as NOP.
- Reset deasserting mid-instruction discards that instruction; the next FETCH reads address 0.
- IMEM_ADDR changes one edge after FETCH (increment) or after EXEC1 (jump).
- Jump timing: JMP/JZ targets override the PC+1 written at the preceding FETCH edge. Next FETCH reads the target, so no delay slot.
- Latency per instruction: 2 cycles (FETCH, EXEC1); LD takes 3 cycles.
- Strobes are combinational and valid for the whole phase cycle. Consumers sample on the rising edge that ends the phase.
- HALT takes effect at the EXEC1 edge. The following FETCH is already suppressed, and PC holds the address after the HALT.

## Test plan
- Reset, then memory[0..2]={0x1000,0x2000,0x0000}: ALU raises REG_WE in its EXEC1. LD raises MEM_RD+E2 in EXEC1 and REG_WE in EXEC2. RETIRED=3 after the NOP; PC=3.
- Memory[0]=0x4010 (JMP 0x10), memory[0x10]=0x3000: second FETCH shows IMEM_ADDR=0x10; MEM_WE pulses in that ST's EXEC1.
- JZ 0x20 with Z=0 → PC=1 at next FETCH. Repeat with Z=1 → PC=0x20.
- PC=0xFF holding NOP → after FETCH, IMEM_ADDR=0x00.
- Opcode 0x7 → ILLEGAL=1 and RETIRED increments. Then HALT (0xF000) → HALTED=1; later FETCHes leave IR/PC/RETIRED unchanged, and E2 stays 0 even though IR=LD was never loaded.
- Assert RST_N low mid-EXEC2 of an LD → outputs immediately reset values, with REG_WE dropping the same cycle. Also drive FETCH and EXEC1 both high → no state change.
